// File: rtl/lsu_stage.sv
// Load/store stage feeding write-back: one bus access per instruction, load formatting, pass-through of ALU results.
// Optional performance counters are compiled in with `define LSU_PERF_CNT_EN.
module lsu_stage #(
    parameter int SB_W = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_is_load,
    input  logic            i_is_store,
    input  logic [2:0]      i_funct3,
    input  logic [31:0]     i_addr,
    input  logic [31:0]     i_store_data,
    input  logic [31:0]     i_res,
    input  logic [3:0]      i_rd_addr,
    input  logic            i_wen,
    input  logic [SB_W-1:0] i_sb,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_we,
    output logic [31:0]     mem_req_addr,
    output logic [31:0]     mem_req_wdata,
    output logic [3:0]      mem_req_wstrb,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_rdata,
    input  logic            mem_rsp_err,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_res,
    output logic [3:0]      o_rd_addr,
    output logic            o_wen,
    output logic [SB_W-1:0] o_sb,
    output logic            o_fault
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]     o_load_cnt,
    output logic [31:0]     o_store_cnt,
    output logic [31:0]     o_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;

    logic [1:0] lane_p0;
    logic [2:0] funct3_p0;
    logic       wen_p0;
    logic       is_load_p0;

    logic accept;
    logic is_mem;
    logic misaligned;

    // Shift the addressed lane down, then sign/zero extend according to funct3.
    function automatic logic [31:0] fmt_load(input logic [31:0] rdata,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  f3);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = rdata >> {lane, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'b000:  return 32'(b);
            3'b001:  return 32'(h);
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] size,
                                              input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                                input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // funct3[1:0] carries the access size; encodings beyond halfword act as word.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lane);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

    assign o_ready    = (state == S_IDLE) | ((state == S_DONE) & i_ready);
    assign accept     = i_valid & o_ready;
    assign is_mem     = i_is_load | i_is_store;
    assign misaligned = is_mem & is_misaligned(i_funct3[1:0], i_addr[1:0]);

    // Accept boundary: instruction attributes needed once the response arrives.
    always_ff @(posedge clock) begin
        if (accept) begin
            lane_p0    <= i_addr[1:0];
            funct3_p0  <= i_funct3;
            wen_p0     <= i_wen;
            is_load_p0 <= i_is_load;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            o_valid       <= 1'b0;
            o_res         <= '0;
            o_rd_addr     <= '0;
            o_wen         <= 1'b0;
            o_sb          <= '0;
            o_fault       <= 1'b0;
        end else if (accept) begin
            o_rd_addr <= i_rd_addr;
            o_sb      <= i_sb;
            if (!is_mem) begin
                state   <= S_DONE;
                o_valid <= 1'b1;
                o_res   <= i_res;
                o_wen   <= i_wen;
                o_fault <= 1'b0;
            end else if (misaligned) begin
                state   <= S_DONE;
                o_valid <= 1'b1;
                o_res   <= '0;
                o_wen   <= 1'b0;
                o_fault <= 1'b1;
            end else begin
                state         <= S_REQ;
                o_valid       <= 1'b0;
                o_res         <= '0;
                o_wen         <= 1'b0;
                o_fault       <= 1'b0;
                mem_req_valid <= 1'b1;
                mem_req_we    <= i_is_store;
                mem_req_addr  <= i_addr;
                mem_req_wdata <= i_is_store ? store_lanes(i_funct3[1:0], i_store_data) : 32'h0;
                mem_req_wstrb <= i_is_store ? store_strb(i_funct3[1:0], i_addr[1:0]) : 4'h0;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (mem_req_ready) begin
                        state         <= S_WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                // Response boundary: fault wins over data, stores never write a register.
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        state   <= S_DONE;
                        o_valid <= 1'b1;
                        if (mem_rsp_err) begin
                            o_fault <= 1'b1;
                            o_wen   <= 1'b0;
                            o_res   <= '0;
                        end else if (is_load_p0) begin
                            o_res <= fmt_load(mem_rsp_rdata, lane_p0, funct3_p0);
                            o_wen <= wen_p0;
                        end else begin
                            o_res <= '0;
                            o_wen <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        state   <= S_IDLE;
                        o_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    logic is_store_p0;
    logic handoff;

    always_ff @(posedge clock) begin
        if (accept) begin
            is_store_p0 <= i_is_store;
        end
    end

    assign handoff = (state == S_DONE) & i_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            o_load_cnt  <= '0;
            o_store_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (handoff & is_load_p0) begin
                o_load_cnt <= o_load_cnt + 32'd1;
            end
            if (handoff & is_store_p0) begin
                o_store_cnt <= o_store_cnt + 32'd1;
            end
            if ((state == S_REQ) | (state == S_WAIT)) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_stage.sv
// Directed testbench for lsu_stage: pass-through, load formatting, stores, stalls, faults and reset.
module tb_lsu_stage;
    localparam int SB_W = 8;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            i_valid;
    logic            o_ready;
    logic            i_is_load;
    logic            i_is_store;
    logic [2:0]      i_funct3;
    logic [31:0]     i_addr;
    logic [31:0]     i_store_data;
    logic [31:0]     i_res;
    logic [3:0]      i_rd_addr;
    logic            i_wen;
    logic [SB_W-1:0] i_sb;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_we;
    logic [31:0]     mem_req_addr;
    logic [31:0]     mem_req_wdata;
    logic [3:0]      mem_req_wstrb;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rsp_rdata;
    logic            mem_rsp_err;
    logic            o_valid;
    logic            i_ready;
    logic [31:0]     o_res;
    logic [3:0]      o_rd_addr;
    logic            o_wen;
    logic [SB_W-1:0] o_sb;
    logic            o_fault;
`ifdef LSU_PERF_CNT_EN
    logic [31:0]     o_load_cnt;
    logic [31:0]     o_store_cnt;
    logic [31:0]     o_stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    lsu_stage #(.SB_W(SB_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_funct3(i_funct3),
        .i_addr(i_addr), .i_store_data(i_store_data), .i_res(i_res),
        .i_rd_addr(i_rd_addr), .i_wen(i_wen), .i_sb(i_sb),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .mem_rsp_err(mem_rsp_err),
        .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res),
        .o_rd_addr(o_rd_addr), .o_wen(o_wen), .o_sb(o_sb), .o_fault(o_fault)
`ifdef LSU_PERF_CNT_EN
        ,
        .o_load_cnt(o_load_cnt), .o_store_cnt(o_store_cnt), .o_stall_cnt(o_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] res, input logic [3:0] rd,
                         input logic wen, input logic [7:0] sb);
        i_valid      = 1'b1;
        i_is_load    = ld;
        i_is_store   = st;
        i_funct3     = f3;
        i_addr       = addr;
        i_store_data = data;
        i_res        = res;
        i_rd_addr    = rd;
        i_wen        = wen;
        i_sb         = sb;
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        issue(1'b1, 1'b0, f3, addr, 32'h0, 32'h5555_5555, 4'd7, 1'b1, 8'h3C);
        mem_req_ready = 1'b1;
        i_ready       = 1'b1;
        step();
        i_valid = 1'b0;
        chk({tag, "_req_valid"}, mem_req_valid, 1);
        chk({tag, "_req_addr"}, mem_req_addr, addr);
        chk({tag, "_req_we"}, mem_req_we, 0);
        chk({tag, "_req_wstrb"}, mem_req_wstrb, 0);
        step();
        chk({tag, "_wait_req_valid"}, mem_req_valid, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rdata;
        step();
        mem_rsp_valid = 1'b0;
        chk({tag, "_o_valid"}, o_valid, 1);
        chk({tag, "_o_res"}, o_res, exp);
        chk({tag, "_o_wen"}, o_wen, 1);
        chk({tag, "_o_rd"}, o_rd_addr, 7);
        chk({tag, "_o_sb"}, o_sb, 8'h3C);
        chk({tag, "_o_fault"}, o_fault, 0);
        step();
        chk({tag, "_idle"}, o_valid, 0);
    endtask

    initial begin
        reset_n       = 1'b0;
        i_valid       = 1'b0;
        i_is_load     = 1'b0;
        i_is_store    = 1'b0;
        i_funct3      = 3'd0;
        i_addr        = 32'h0;
        i_store_data  = 32'h0;
        i_res         = 32'h0;
        i_rd_addr     = 4'd0;
        i_wen         = 1'b0;
        i_sb          = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        mem_rsp_err   = 1'b0;
        i_ready       = 1'b0;
        repeat (2) step();

        chk("rst_o_valid", o_valid, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_o_res", o_res, 0);
        chk("rst_o_rd", o_rd_addr, 0);
        chk("rst_o_wen", o_wen, 0);
        chk("rst_o_sb", o_sb, 0);
        chk("rst_o_fault", o_fault, 0);
        chk("rst_o_ready", o_ready, 1);
        reset_n = 1'b1;
        step();

        // Non-memory pass-through, held while write-back stalls
        issue(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h1234, 4'd5, 1'b1, 8'hA5);
        step();
        i_valid = 1'b0;
        chk("alu_o_valid", o_valid, 1);
        chk("alu_o_res", o_res, 32'h1234);
        chk("alu_o_rd", o_rd_addr, 5);
        chk("alu_o_wen", o_wen, 1);
        chk("alu_o_sb", o_sb, 8'hA5);
        chk("alu_o_fault", o_fault, 0);
        #1 chk("alu_o_ready_stall", o_ready, 0);

        // Back-to-back non-memory: one result per cycle
        i_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            issue(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h1111 * k, 4'(k), 1'b1, 8'(k));
            #1 chk("b2b_o_ready", o_ready, 1);
            step();
            chk("b2b_o_valid", o_valid, 1);
            chk("b2b_o_res", o_res, 32'h1111 * k);
            chk("b2b_o_rd", o_rd_addr, 32'(k));
        end
        i_valid = 1'b0;
        step();
        chk("b2b_drain", o_valid, 0);

        // Load formatting
        load_chk("lb", 3'b000, 32'h8000_0003, 32'h80FF_0000, 32'hFFFF_FF80);
        load_chk("lbu", 3'b100, 32'h8000_0003, 32'h80FF_0000, 32'h0000_0080);
        load_chk("lhu", 3'b101, 32'h8000_0002, 32'h80FF_0000, 32'h0000_80FF);
        load_chk("lh", 3'b001, 32'h8000_0002, 32'h80FF_0000, 32'hFFFF_80FF);
        load_chk("lw", 3'b010, 32'h8000_0000, 32'h80FF_0000, 32'h80FF_0000);

        // Halfword store with bus backpressure
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 4'd9, 1'b1, 8'h11);
        mem_req_ready = 1'b0;
        step();
        i_valid = 1'b0;
        chk("sh_req_valid", mem_req_valid, 1);
        chk("sh_req_we", mem_req_we, 1);
        chk("sh_req_wstrb", mem_req_wstrb, 4'b1100);
        chk("sh_req_wdata", mem_req_wdata, 32'hBEEF_BEEF);
        chk("sh_req_addr", mem_req_addr, 32'h0000_0102);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("stall_req_valid", mem_req_valid, 1);
            chk("stall_req_wdata", mem_req_wdata, 32'hBEEF_BEEF);
            chk("stall_req_wstrb", mem_req_wstrb, 4'b1100);
            chk("stall_req_addr", mem_req_addr, 32'h0000_0102);
            chk("stall_o_ready", o_ready, 0);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("sh_wait_req_valid", mem_req_valid, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hFFFF_FFFF;
        step();
        mem_rsp_valid = 1'b0;
        chk("sh_o_valid", o_valid, 1);
        chk("sh_o_wen", o_wen, 0);
        chk("sh_o_res", o_res, 0);
        chk("sh_o_fault", o_fault, 0);
        step();

        // Bus error on a word load
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 4'd3, 1'b1, 8'h0);
        mem_req_ready = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = 1'b1;
        mem_rsp_rdata = 32'h1234_5678;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        chk("err_o_valid", o_valid, 1);
        chk("err_o_fault", o_fault, 1);
        chk("err_o_wen", o_wen, 0);
        chk("err_o_res", o_res, 0);
        step();
        chk("err_drain", o_valid, 0);

        // Misaligned word load: no bus request, result held under stall
        i_ready = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 4'd4, 1'b1, 8'h0);
        step();
        i_valid = 1'b0;
        chk("mis_req_valid", mem_req_valid, 0);
        chk("mis_o_valid", o_valid, 1);
        chk("mis_o_fault", o_fault, 1);
        chk("mis_o_wen", o_wen, 0);
        chk("mis_o_rd", o_rd_addr, 4);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("mis_hold_valid", o_valid, 1);
            chk("mis_hold_fault", o_fault, 1);
            chk("mis_hold_rd", o_rd_addr, 4);
            chk("mis_hold_req", mem_req_valid, 0);
            chk("mis_hold_ready", o_ready, 0);
        end
        i_ready = 1'b1;
        step();
        chk("mis_drain", o_valid, 0);

        // Reset while a request is pending
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0, 4'd2, 1'b1, 8'h0);
        mem_req_ready = 1'b0;
        step();
        i_valid = 1'b0;
        chk("rreq_req_valid", mem_req_valid, 1);
        reset_n = 1'b0;
        #1 chk("rreq_req_drop", mem_req_valid, 0);
        chk("rreq_o_valid", o_valid, 0);
        reset_n = 1'b1;
        #1 chk("rreq_o_ready", o_ready, 1);

        // Reset while waiting for the response; the late response is ignored
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h0, 4'd2, 1'b1, 8'h0);
        mem_req_ready = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        mem_req_ready = 1'b0;
        chk("rwait_req_valid", mem_req_valid, 0);
        reset_n = 1'b0;
        #1 chk("rwait_o_valid", o_valid, 0);
        chk("rwait_req_drop", mem_req_valid, 0);
        reset_n = 1'b1;
        #1 chk("rwait_o_ready", o_ready, 1);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hAAAA_AAAA;
        step();
        mem_rsp_valid = 1'b0;
        chk("late_rsp_o_valid", o_valid, 0);
        step();
        chk("late_rsp_o_valid2", o_valid, 0);

        // Stage is usable again after the reset
        issue(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'hCAFE, 4'd6, 1'b1, 8'h0);
        step();
        i_valid = 1'b0;
        chk("post_rst_o_valid", o_valid, 1);
        chk("post_rst_o_res", o_res, 32'hCAFE);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
